// File: rtl/reg_file_sb.sv
// 32x32 register file with two write-first read ports and a per-register
// in-flight write scoreboard (saturating counters, flushable).

module reg_file_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] MAX = '1;

  // The top only lets inc through at MAX when a dec cancels it, so the
  // MAX / zero guards below are defensive: the counter never wraps.
  always_ff @(posedge clk or posedge rst)
    if (rst)                                cnt <= '0;
    else if (clr)                           cnt <= '0;
    else if (inc && !dec && cnt != MAX)     cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)      cnt <= cnt - 1'b1;
endmodule

module reg_file_sb_rd #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREG-1:0][31:0]        regs,
  input  logic [NREG-1:0][CNT_W-1:0]   cnt,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [31:0]                  wd,
  output logic [31:0]                  data,
  output logic                         busy
);
  logic             hit;
  logic [CNT_W-1:0] c;

  // Busy reflects the count after this cycle's writeback, so the last
  // outstanding write clears busy in the same cycle its data is bypassed.
  always_comb begin
    hit  = we && (wa == addr) && (addr != '0);
    c    = cnt[addr];
    data = regs[addr];
    if (addr == '0) data = '0;
    else if (hit)   data = wd;
    busy = (addr != '0) && (c != '0) && !(hit && c == CNT_W'(1));
  end
endmodule

module reg_file_sb #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  output logic        ra_busy,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  output logic        rb_busy,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        iss_en,
  input  logic [4:0]  iss_addr,
  output logic        iss_ok,
  input  logic        flush,
  output logic        inflight_any
);
  localparam int AW    = 5;
  localparam int NPORT = 2;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [NREG-1:0][31:0]       regs;
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:1]             inc;
  logic [NREG-1:1]             dec;
  logic                        dec_hit;

  logic [NPORT-1:0][AW-1:0]    rd_addr;
  logic [NPORT-1:0][31:0]      rd_data;
  logic [NPORT-1:0]            rd_busy;

  // Storage; entry 0 is held at zero and never written.
  always_ff @(posedge clk or posedge rst)
    if (rst)                  regs     <= '0;
    else if (we && wa != '0)  regs[wa] <= wd;

  // A full counter can still accept an issue when a writeback to the same
  // register retires one slot in the same cycle.
  always_comb begin
    dec_hit = we && (wa == iss_addr);
    iss_ok  = iss_en && ((iss_addr == '0) || (cnt[iss_addr] != MAX) || dec_hit);
    inc     = '0;
    dec     = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_ok && (iss_addr == AW'(r));
      dec[r] = we && (wa == AW'(r)) && (cnt[r] != '0);
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    reg_file_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .clr (flush),
      .cnt (cnt[r])
    );
  end

  assign rd_addr = {rb_addr, ra_addr};

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    reg_file_sb_rd #(.NREG(NREG), .CNT_W(CNT_W), .AW(AW)) u_rd (
      .addr (rd_addr[p]),
      .regs (regs),
      .cnt  (cnt),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .data (rd_data[p]),
      .busy (rd_busy[p])
    );
  end

  assign ra_data      = rd_data[0];
  assign ra_busy      = rd_busy[0];
  assign rb_data      = rd_data[1];
  assign rb_busy      = rd_busy[1];
  assign inflight_any = |cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Table-driven bench for reg_file_sb: each step drives inputs, queues the
// expected outputs and compares them mid-cycle; async reset is hand-sequenced.

module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra_addr = '0, rb_addr = '0, wa = '0, iss_addr = '0;
  logic [31:0] ra_data, rb_data, wd = '0;
  logic        ra_busy, rb_busy, iss_ok, inflight_any;
  logic        we = 1'b0, iss_en = 1'b0, flush = 1'b0;

  reg_file_sb #(.NREG(32), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ra_addr      (ra_addr),
    .ra_data      (ra_data),
    .ra_busy      (ra_busy),
    .rb_addr      (rb_addr),
    .rb_data      (rb_data),
    .rb_busy      (rb_busy),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .iss_en       (iss_en),
    .iss_addr     (iss_addr),
    .iss_ok       (iss_ok),
    .flush        (flush),
    .inflight_any (inflight_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  ra, rb;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
  } in_t;

  typedef struct {
    logic [31:0] rad;
    logic        rab;
    logic [31:0] rbd;
    logic        rbb;
    logic        ok;
    logic        any;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, step, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic [4:0] ra, input logic [4:0] rb,
    input logic w, input logic [4:0] a, input logic [31:0] d,
    input logic ie, input logic [4:0] ia, input logic fl,
    input logic [31:0] rad, input logic rab, input logic [31:0] rbd,
    input logic rbb, input logic ok, input logic any);
    vec_t v;
    v.i = '{r, ra, rb, w, a, d, ie, ia, fl};
    v.e = '{rad, rab, rbd, rbb, ok, any};
    return v;
  endfunction

  task automatic apply(input in_t i);
    rst = i.rst; ra_addr = i.ra; rb_addr = i.rb;
    we = i.we; wa = i.wa; wd = i.wd;
    iss_en = i.ie; iss_addr = i.ia; flush = i.fl;
  endtask

  initial begin
    exp_t e;
    //                rst ra rb we wa wd            ie ia fl | rad           rab rbd           rbb ok any
    tbl.push_back(mk(1, 5, 0, 0, 0, 32'h0,        1, 3, 0,  32'h0,        0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,  32'hDEADBEEF, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 5, 5, 0, 0, 32'h0,        0, 0, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 1, 0, 32'hFFFFFFFF, 1, 0, 0,  32'h0,        0, 32'hDEADBEEF, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  32'h0,        0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 7, 0, 0, 32'h0,        1, 7, 0,  32'h0,        0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 7, 0, 0, 32'h0,        1, 7, 0,  32'h0,        0, 32'h0,        1, 1, 1));
    tbl.push_back(mk(0, 0, 7, 1, 7, 32'h11,       0, 0, 0,  32'h0,        0, 32'h11,       1, 0, 1));
    tbl.push_back(mk(0, 0, 7, 1, 7, 32'h12,       0, 0, 0,  32'h0,        0, 32'h12,       0, 0, 1));
    tbl.push_back(mk(0, 7, 7, 0, 0, 32'h0,        0, 0, 0,  32'h12,       0, 32'h12,       0, 0, 0));
    tbl.push_back(mk(0, 7, 0, 1, 7, 32'h34,       0, 0, 0,  32'h34,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 32'h0,        1, 3, 0,  32'h34,       0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 32'h0,        1, 3, 0,  32'h0,        1, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 32'h0,        1, 3, 0,  32'h0,        1, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 32'h0,        1, 3, 0,  32'h0,        1, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 1, 3, 32'h55,       1, 3, 0,  32'h55,       1, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 32'h0,        1, 3, 0,  32'h55,       1, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 9, 0,  32'h0,        0, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 9, 0,  32'h0,        0, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 9, 4, 0, 0, 32'h0,        1, 4, 0,  32'h0,        1, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 9, 4, 1, 4, 32'h44,       1, 9, 1,  32'h0,        1, 32'h44,       0, 1, 1));
    tbl.push_back(mk(0, 9, 4, 0, 0, 32'h0,        1, 3, 0,  32'h0,        0, 32'h44,       0, 1, 0));
    tbl.push_back(mk(0, 3, 5, 0, 0, 32'h0,        0, 0, 0,  32'h55,       1, 32'hDEADBEEF, 0, 0, 1));

    for (int s = 0; s < tbl.size(); s++) begin
      @(negedge clk);
      apply(tbl[s].i);
      sb.push_back(tbl[s].e);
      #2;
      e = sb.pop_front();
      chk("ra_data",      s, ra_data,      e.rad);
      chk("ra_busy",      s, ra_busy,      e.rab);
      chk("rb_data",      s, rb_data,      e.rbd);
      chk("rb_busy",      s, rb_busy,      e.rbb);
      chk("iss_ok",       s, iss_ok,       e.ok);
      chk("inflight_any", s, inflight_any, e.any);
    end

    // Asynchronous reset between edges: r3 holds 0x55 and is busy right now.
    iss_en = 1'b0; we = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_ra_data",  100, ra_data,      32'h0);
    chk("async_ra_busy",  100, ra_busy,      1'b0);
    chk("async_rb_data",  100, rb_data,      32'h0);
    chk("async_inflight", 100, inflight_any, 1'b0);
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a);
      #1;
      chk("reset_ra_data", 200 + a, ra_data, 32'h0);
    end

    // First write after release lands on the first rising edge.
    @(negedge clk);
    rst = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hA5A5_0001; ra_addr = 5'd5; rb_addr = 5'd7;
    #2;
    chk("post_rst_bypass", 300, ra_data, 32'hA5A5_0001);
    @(negedge clk);
    we = 1'b0;
    #2;
    chk("post_rst_store",  301, ra_data, 32'hA5A5_0001);
    chk("post_rst_r7",     301, rb_data, 32'h0);
    chk("post_rst_busy",   301, rb_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (fixed at 32; address width 5).
REQ-002 SHALL have parameter CNT_W, default 2, width of each per-register in-flight counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ra_addr  input  5  read port A address.
REQ-006 ra_data  output  32  read port A data.
REQ-007 ra_busy  output  1  port A register has an outstanding write.
REQ-008 rb_addr  input  5  read port B address.
REQ-009 rb_data  output  32  read port B data.
REQ-010 rb_busy  output  1  port B register has an outstanding write.
REQ-011 we  input  1  writeback enable.
REQ-012 wa  input  5  writeback address.
REQ-013 wd  input  32  writeback data.
REQ-014 iss_en  input  1  issue request: an instruction will write iss_addr.
REQ-015 iss_addr  input  5  destination of the issuing instruction.
REQ-016 iss_ok  output  1  issue accepted this cycle.
REQ-017 flush  input  1  discard all outstanding-write tracking.
REQ-018 inflight_any  output  1  at least one counter is non-zero.

Function
REQ-019 Storage: 32 x 32-bit registers; register 0 reads 0, is never written, and is never busy.
REQ-020 Write: on a rising clk with we=1 and wa!=0, reg[wa] <= wd; with we=0 or wa=0, storage is unchanged.
REQ-021 Read: ra_data/rb_data are combinational from the address, with no clock latency.
REQ-022 Bypass: when we=1, wa!=0 and wa equals the port address, the port outputs wd in the same cycle (write-first).
REQ-023 Counters: each register 1..31 has a CNT_W-bit unsigned in-flight count cnt[r].
REQ-024 Issue acceptance: iss_ok = iss_en & (iss_addr==0 | cnt[iss_addr]!=3 | dec_hit), where dec_hit = we & wa==iss_addr.
REQ-025 Counter update per clock, for each r!=0: inc = iss_ok & iss_addr==r; dec = we & wa==r & cnt[r]!=0.
REQ-026 inc only: cnt[r]+1; dec only: cnt[r]-1; both or neither: unchanged; the counter never wraps.
REQ-027 A writeback to a register whose count is 0 updates storage and leaves the count at 0 (no underflow).
REQ-028 Busy: ra_busy = (ra_addr!=0) & (cnt[ra_addr] - dec_hit_A) != 0, where dec_hit_A = we & wa==ra_addr & cnt!=0; rb_busy is identical for port B.
REQ-029 Busy reflects the count after that cycle's writeback, so the final writeback clears busy combinationally together with the bypassed data.
REQ-030 An issue in the same cycle does not affect busy until the next cycle.
REQ-031 Flush: on a rising clk with flush=1, all counters go to 0; any iss_en/we in that cycle still write storage, but their counter effects are discarded.
REQ-032 inflight_any = OR over r of (cnt[r]!=0), from registered state only.
REQ-033 Simultaneous: read, write, issue and flush on the same address in one cycle are all legal and resolve per REQ-020..REQ-031.

Reset
REQ-034 While rst=1: all 32 registers = 0, all counters = 0, hence ra_busy=rb_busy=0 and inflight_any=0.
REQ-035 Reset takes effect immediately and asynchronously, including mid-operation; the first write after release occurs on the first rising clk with rst=0.
REQ-036 iss_ok stays combinational during reset and is computed from the reset counter values.

Verification
REQ-037 Write then read: we=1, wa=5, wd=0xDEADBEEF, ra_addr=5 -> ra_data=0xDEADBEEF in the same cycle (bypass) and on the next cycle from storage.
REQ-038 Register 0: we=1, wa=0, wd=0xFFFFFFFF, then ra_addr=0 -> ra_data=0 and ra_busy=0; iss_en with iss_addr=0 -> iss_ok=1, inflight_any stays 0.
REQ-039 Scoreboard: issue r7 twice -> cnt=2, rb_addr=7 gives rb_busy=1; first writeback -> busy stays 1; second writeback with wd=0x12 -> rb_busy=0 and rb_data=0x12 in that cycle.
REQ-040 Saturation: four issues to r3 with no writeback -> 4th iss_ok=0, cnt=3; 4th issue repeated with we=1, wa=3 -> iss_ok=1, cnt stays 3.
REQ-041 Flush: cnt[9]=2 and cnt[4]=1, assert flush with iss_en to r9 -> all busy=0 and inflight_any=0 next cycle.
REQ-042 Async reset mid-run: rst pulsed between clock edges with registers written -> outputs zero before the next edge; ra_data=0 for all addresses.
